// File: rtl/m3_dequant_zz_writer.sv
// m3_dequant_zz_writer: dequantizes decoded coefficients and writes them in zig-zag order to the S' DPRAM
module m3_dequant_zz_writer #(
  parameter logic [6:0] ADDR_BASE = 7'd0,
  parameter int         VAL_W     = 9
) (
  input  logic                    CLOCK_50_I,
  input  logic                    Resetn,
  input  logic                    Block_start,
  input  logic                    Q_matrix,
  input  logic                    coef_valid,
  output logic                    coef_ready,
  input  logic [1:0]              coef_cmd,
  input  logic signed [VAL_W-1:0] coef_value,
  input  logic [2:0]              coef_run,
  output logic [6:0]              RAM_address,
  output logic [31:0]             RAM_write_data,
  output logic                    RAM_we,
  output logic                    Block_done,
  output logic                    Overrun_err
);
  typedef enum logic [2:0] {S_ZZ_IDLE, S_ZZ_ACCEPT, S_ZZ_RUN, S_ZZ_FILL, S_ZZ_DONE} state_t;
  localparam logic [5:0] ZZ [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63};
  state_t      state_q, state_d;
  logic [5:0]  idx_q, idx_d;
  logic [3:0]  run_q, run_d;
  logic        qsel_q, qsel_d;
  logic        ready_q, ready_d, we_q, we_d, done_q, done_d, ovr_q, ovr_d;
  logic [6:0]  addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        xfer, wr_val, wr, last;
  logic [5:0]  pos;
  logic [3:0]  diag;
  logic [2:0]  shift;
  logic [31:0] ext;
  assign coef_ready     = ready_q;
  assign RAM_we         = we_q;
  assign RAM_address    = addr_q;
  assign RAM_write_data = data_q;
  assign Block_done     = done_q;
  assign Overrun_err    = ovr_q;
  // next-state, write issue and dequantization; Block_start overrides any transfer
  always_comb begin
    pos    = ZZ[idx_q];
    diag   = {1'b0, pos[5:3]} + {1'b0, pos[2:0]};
    shift  = qsel_q ? (diag == 4'd0 ? 3'd3 : diag <= 4'd3 ? 3'd1 : diag <= 4'd5 ? 3'd2 :
                       diag <= 4'd7 ? 3'd3 : diag <= 4'd10 ? 3'd4 : 3'd5)
                    : (diag == 4'd0 ? 3'd3 : diag == 4'd1 ? 3'd2 : diag <= 4'd3 ? 3'd3 :
                       diag <= 4'd5 ? 3'd4 : diag <= 4'd7 ? 3'd5 : 3'd6);
    ext    = {{(32-VAL_W){coef_value[VAL_W-1]}}, coef_value};
    xfer   = state_q == S_ZZ_ACCEPT && coef_valid && !Block_start;
    wr_val = xfer && coef_cmd == 2'b00;
    wr     = wr_val || state_q == S_ZZ_RUN || state_q == S_ZZ_FILL;
    last   = wr && idx_q == 6'd63;
    we_d   = wr;
    addr_d = wr ? ADDR_BASE + {1'b0, pos} : 7'd0;
    data_d = wr_val ? ext << shift : 32'd0;
    done_d = state_q == S_ZZ_DONE;
    qsel_d = Block_start ? Q_matrix : qsel_q;
    idx_d  = Block_start ? 6'd0 : wr ? idx_q + 6'd1 : idx_q;
    run_d  = xfer && coef_cmd == 2'b01 ? (coef_run == 3'd0 ? 4'd8 : {1'b0, coef_run}) :
             state_q == S_ZZ_RUN ? run_q - 4'd1 : run_q;
    ovr_d  = Block_start ? 1'b0 : ovr_q || (state_q == S_ZZ_RUN && last && run_q != 4'd1);
    state_d = Block_start ? S_ZZ_ACCEPT : last ? S_ZZ_DONE :
              state_q == S_ZZ_ACCEPT ? (xfer && coef_cmd == 2'b01 ? S_ZZ_RUN :
                                        xfer && coef_cmd == 2'b10 ? S_ZZ_FILL : S_ZZ_ACCEPT) :
              state_q == S_ZZ_RUN ? (run_q == 4'd1 ? S_ZZ_ACCEPT : S_ZZ_RUN) :
              state_q == S_ZZ_FILL ? S_ZZ_FILL : S_ZZ_IDLE;
    ready_d = state_d == S_ZZ_ACCEPT;
  end
  // state and registered outputs; reset abandons any block in flight
  always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= S_ZZ_IDLE;
      idx_q   <= 6'd0;
      run_q   <= 4'd0;
      qsel_q  <= 1'b0;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 7'd0;
      data_q  <= 32'd0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      run_q   <= run_d;
      qsel_q  <= qsel_d;
      ready_q <= ready_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end
endmodule
